// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package mdu_iter_pkg;

    localparam logic [1:0] MDU_MUL   = 2'b00;
    localparam logic [1:0] MDU_MULHU = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_REMU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // op[1] selects divide, op[0] selects the upper register (hi / remainder).
    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

    function automatic logic op_uses_hi(input logic [1:0] op_code);
        return op_code[0];
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on {hi, lo}.
module mdu_iter_step #(
    parameter int WIDTH = 16
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb} : '0);
        // Remainder may reach WIDTH+1 bits after the shift; only the low bits survive a subtract.
        shifted = {hi_in, lo_in[WIDTH-1]};
        borrow  = shifted < {1'b0, opb};
        diff    = shifted[WIDTH-1:0] - opb;
        if (div_mode) begin
            hi_out = borrow ? shifted[WIDTH-1:0] : diff;
            lo_out = {lo_in[WIDTH-2:0], ~borrow};
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide unit: IDLE -> RUN (WIDTH steps) -> DONE write pulse.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [2:0]       dest,
    output logic             busy,
    output logic             write,
    output logic [2:0]       writeregsel,
    output logic [WIDTH-1:0] writedata,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       dest_q, dest_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_step, lo_step;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (op_is_div(op_q)),
        .hi_in    (hi_q),
        .lo_in    (lo_q),
        .opb      (opb_q),
        .hi_out   (hi_step),
        .lo_out   (lo_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opb_d   = opb_q;
        dest_d  = dest_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    opb_d   = opb;
                    dest_d  = dest;
                    hi_d    = '0;
                    lo_d    = opa;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                hi_d = hi_step;
                lo_d = lo_step;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opb_q   <= '0;
            dest_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            dest_q  <= dest_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Divide by zero needs no special datapath: the quotient fills with ones and opa shifts into rem.
    always_comb begin
        busy        = (state_q != S_IDLE);
        write       = (state_q == S_DONE);
        writeregsel = dest_q;
        writedata   = '0;
        err         = 1'b0;
        if (write) begin
            writedata = op_uses_hi(op_q) ? hi_q : lo_q;
            err       = op_is_div(op_q) && (opb_q == '0);
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed cases plus random operations against an arithmetic model.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int WIDTH = 16;
    localparam int LAT   = 17;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = '0;
    logic [WIDTH-1:0] opa = '0;
    logic [WIDTH-1:0] opb = '0;
    logic [2:0]       dest = '0;
    logic             busy;
    logic             write;
    logic [2:0]       writeregsel;
    logic [WIDTH-1:0] writedata;
    logic             err;

    typedef struct {
        int               cyc;
        logic [2:0]       dest;
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   win_lo = 1;
    int   win_hi = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   s0;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .dest        (dest),
        .busy        (busy),
        .write       (write),
        .writeregsel (writeregsel),
        .writedata   (writedata),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [2:0] d, input int c);
        exp_t        e;
        int unsigned prod;
        prod  = 32'(a) * 32'(b);
        e.cyc = c;
        e.dest = d;
        e.err = 1'b0;
        e.data = '0;
        case (o)
            MDU_MUL:   e.data = prod[15:0];
            MDU_MULHU: e.data = prod[31:16];
            MDU_DIVU: begin
                if (b == 0) begin e.data = 16'hFFFF; e.err = 1'b1; end
                else e.data = a / b;
            end
            default: begin
                if (b == 0) begin e.data = a; e.err = 1'b1; end
                else e.data = a % b;
            end
        endcase
        return e;
    endfunction

    // Called on a falling edge; the rising edge that follows accepts the request.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [2:0] d);
        op = o; opa = a; opb = b; dest = d; start = 1'b1;
        sbq.push_back(model(o, a, b, d, cyc + LAT));
        win_lo = cyc + 1;
        win_hi = cyc + LAT;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        opa   = 16'($urandom);
        opb   = 16'($urandom);
        dest  = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc <= win_hi && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (cyc <= win_hi) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: still busy at cycle %0d expected idle after %0d", cyc, win_hi);
        end
    endtask

    always @(posedge clk) begin
        #1;
        begin
            logic exp_busy;
            logic exp_wr;
            exp_busy = (cyc >= win_lo) && (cyc <= win_hi);
            exp_wr   = (sbq.size() > 0) && (sbq[0].cyc == cyc);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("write", 32'(write), 32'(exp_wr));
            if (exp_wr) begin
                mon_e = sbq.pop_front();
                if (write) begin
                    chk("writeregsel", 32'(writeregsel), 32'(mon_e.dest));
                    chk("writedata", 32'(writedata), 32'(mon_e.data));
                    chk("err", 32'(err), 32'(mon_e.err));
                end
            end else begin
                chk("writedata_idle", 32'(writedata), 32'(0));
                chk("err_idle", 32'(err), 32'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_write", 32'(write), 32'(0));
        chk("reset_writeregsel", 32'(writeregsel), 32'(0));
        chk("reset_writedata", 32'(writedata), 32'(0));
        chk("reset_err", 32'(err), 32'(0));

        issue(MDU_MUL, 16'd3, 16'd5, 3'd2);        wait_idle();
        issue(MDU_MUL, 16'hFFFF, 16'hFFFF, 3'd1);  wait_idle();
        issue(MDU_MULHU, 16'hFFFF, 16'hFFFF, 3'd3); wait_idle();
        issue(MDU_DIVU, 16'd100, 16'd7, 3'd4);     wait_idle();
        issue(MDU_REMU, 16'd100, 16'd7, 3'd5);     wait_idle();
        issue(MDU_DIVU, 16'd1234, 16'd0, 3'd6);    wait_idle();
        issue(MDU_REMU, 16'd1234, 16'd0, 3'd7);    wait_idle();

        // start during RUN and during DONE must be ignored; back-to-back start at T+18 accepted
        s0 = cyc;
        issue(MDU_MUL, 16'd9, 16'd11, 3'd4);
        while (cyc < s0 + 5) @(negedge clk);
        op = MDU_DIVU; opa = 16'd77; opb = 16'd3; dest = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < win_hi) @(negedge clk);
        op = MDU_REMU; opa = 16'd500; opb = 16'd9; dest = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(MDU_MULHU, 16'hABCD, 16'h1234, 3'd1);
        wait_idle();

        // reset mid-RUN discards the operation
        s0 = cyc;
        issue(MDU_MUL, 16'd200, 16'd300, 3'd3);
        while (cyc < s0 + 8) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        win_hi = cyc;
        @(negedge clk);
        rst = 1'b0;
        while (cyc < s0 + 19) @(negedge clk);
        issue(MDU_MUL, 16'd6, 16'd7, 3'd5);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            logic [1:0]       r_op;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            r_op = 2'($urandom);
            r_a  = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       r_b = '0;
                1:       r_b = 16'($urandom_range(1, 15));
                2:       r_b = 16'hFFFF;
                default: r_b = 16'($urandom);
            endcase
            issue(r_op, r_a, r_b, 3'($urandom));
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
